// File: rtl/ipd_servo_sat.sv
// I-PD servo controller: integral on error, P and D on measured position,
// saturating arithmetic with anti-windup, one shared multiplier sequenced by an FSM.
module ipd_servo_sat #(
    parameter int unsigned W    = 13,
    parameter int unsigned FRAC = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] Pot,
    input  logic signed [W-1:0] Ref,
    input  logic signed [W-1:0] kp,
    input  logic signed [W-1:0] ki,
    input  logic signed [W-1:0] kd,
    output logic signed [W-1:0] salida,
    output logic                done,
    output logic                busy,
    output logic                sat
);

    localparam int unsigned EW = W + 1;
    localparam int unsigned PW = W + EW;
    localparam int unsigned SW = PW - FRAC;
    localparam int unsigned AW = SW + 3;

    localparam logic signed [W-1:0]  MAX_W = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  MIN_W = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [AW-1:0] MAX_A = AW'(MAX_W);
    localparam logic signed [AW-1:0] MIN_A = AW'(MIN_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MUL_I, S_MUL_P, S_MUL_D, S_ACC, S_OUT
    } state_t;

    function automatic logic signed [W-1:0] sat_w(input logic signed [AW-1:0] x);
        if (x > MAX_A)      return MAX_W;
        else if (x < MIN_A) return MIN_W;
        else                return W'(x);
    endfunction

    function automatic logic clamps(input logic signed [AW-1:0] x);
        return (x > MAX_A) || (x < MIN_A);
    endfunction

    state_t state_q, state_d;
    logic signed [W-1:0]  pot_in_q, pot_in_d, ref_in_q, ref_in_d;
    logic signed [W-1:0]  kp_in_q, kp_in_d, ki_in_q, ki_in_d, kd_in_q, kd_in_d;
    logic signed [EW-1:0] e_q, e_d, dy_q, dy_d;
    logic signed [W-1:0]  i_q, i_d, inew_q, inew_d, yprev_q, yprev_d;
    logic                 iclamp_q, iclamp_d;
    logic signed [SW-1:0] p_q, p_d, d_q, d_d;
    logic signed [AW-1:0] u_q, u_d;
    logic signed [W-1:0]  salida_q, salida_d;
    logic                 done_q, done_d, busy_q, busy_d, sat_q, sat_d;
    logic                 hi_q, hi_d, lo_q, lo_d, first_q, first_d;

    // shared multiplier, operands selected by the current FSM step
    logic signed [W-1:0]  mul_a;
    logic signed [EW-1:0] mul_b;
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] prod_sh;
    logic signed [AW-1:0] i_sum;
    logic                 hold;

    assign prod    = PW'(mul_a) * PW'(mul_b);
    assign prod_sh = SW'(prod >>> FRAC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pot_in_q <= '0;
            ref_in_q <= '0;
            kp_in_q  <= '0;
            ki_in_q  <= '0;
            kd_in_q  <= '0;
            e_q      <= '0;
            dy_q     <= '0;
            i_q      <= '0;
            inew_q   <= '0;
            iclamp_q <= 1'b0;
            yprev_q  <= '0;
            p_q      <= '0;
            d_q      <= '0;
            u_q      <= '0;
            salida_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            sat_q    <= 1'b0;
            hi_q     <= 1'b0;
            lo_q     <= 1'b0;
            first_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            pot_in_q <= pot_in_d;
            ref_in_q <= ref_in_d;
            kp_in_q  <= kp_in_d;
            ki_in_q  <= ki_in_d;
            kd_in_q  <= kd_in_d;
            e_q      <= e_d;
            dy_q     <= dy_d;
            i_q      <= i_d;
            inew_q   <= inew_d;
            iclamp_q <= iclamp_d;
            yprev_q  <= yprev_d;
            p_q      <= p_d;
            d_q      <= d_d;
            u_q      <= u_d;
            salida_q <= salida_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            sat_q    <= sat_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            first_q  <= first_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pot_in_d = pot_in_q;
        ref_in_d = ref_in_q;
        kp_in_d  = kp_in_q;
        ki_in_d  = ki_in_q;
        kd_in_d  = kd_in_q;
        e_d      = e_q;
        dy_d     = dy_q;
        i_d      = i_q;
        inew_d   = inew_q;
        iclamp_d = iclamp_q;
        yprev_d  = yprev_q;
        p_d      = p_q;
        d_d      = d_q;
        u_d      = u_q;
        salida_d = salida_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        sat_d    = sat_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        first_d  = first_q;
        mul_a    = '0;
        mul_b    = '0;
        i_sum    = '0;
        hold     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d  = S_LOAD;
                    busy_d   = 1'b1;
                    pot_in_d = Pot;
                    ref_in_d = Ref;
                    kp_in_d  = kp;
                    ki_in_d  = ki;
                    kd_in_d  = kd;
                end
            end
            S_LOAD: begin
                e_d     = EW'(ref_in_q) - EW'(pot_in_q);
                dy_d    = first_q ? '0 : EW'(pot_in_q) - EW'(yprev_q);
                state_d = S_MUL_I;
            end
            S_MUL_I: begin
                mul_a = ki_in_q;
                mul_b = e_q;
                i_sum = AW'(i_q) + AW'(prod_sh);
                // conditional integration: freeze I while pushing further into a saturated output
                hold  = (hi_q && !prod_sh[SW-1] && (prod_sh != '0)) || (lo_q && prod_sh[SW-1]);
                if (hold) begin
                    inew_d   = i_q;
                    iclamp_d = 1'b0;
                end else begin
                    inew_d   = sat_w(i_sum);
                    iclamp_d = clamps(i_sum);
                end
                state_d = S_MUL_P;
            end
            S_MUL_P: begin
                mul_a   = kp_in_q;
                mul_b   = EW'(pot_in_q);
                p_d     = prod_sh;
                state_d = S_MUL_D;
            end
            S_MUL_D: begin
                mul_a   = kd_in_q;
                mul_b   = dy_q;
                d_d     = prod_sh;
                state_d = S_ACC;
            end
            S_ACC: begin
                u_d     = AW'(inew_q) - AW'(p_q) - AW'(d_q);
                busy_d  = 1'b0;
                state_d = S_OUT;
            end
            S_OUT: begin
                salida_d = sat_w(u_q);
                hi_d     = u_q > MAX_A;
                lo_d     = u_q < MIN_A;
                sat_d    = clamps(u_q) || iclamp_q;
                i_d      = inew_q;
                yprev_d  = pot_in_q;
                first_d  = 1'b0;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign salida = salida_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign sat    = sat_q;

endmodule

// File: tb/tb_ipd_servo_sat.sv
// Self-checking bench for ipd_servo_sat: directed vector table, handshake/reset
// sequences and randomized samples against an integer reference model.
module tb_ipd_servo_sat;

    localparam int W    = 13;
    localparam int FRAC = 8;
    localparam longint MAXV = 4095;
    localparam longint MINV = -4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic signed [W-1:0] Pot = '0, Ref = '0, kp = '0, ki = '0, kd = '0;
    logic signed [W-1:0] salida;
    logic done, busy, sat;

    int n_checks = 0;
    int n_err    = 0;

    ipd_servo_sat #(.W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .en(en),
        .Pot(Pot), .Ref(Ref), .kp(kp), .ki(ki), .kd(kd),
        .salida(salida), .done(done), .busy(busy), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference model state
    longint m_i, m_yprev;
    bit     m_first, m_hi, m_lo;

    function automatic longint clampw(input longint x);
        return (x > MAXV) ? MAXV : (x < MINV) ? MINV : x;
    endfunction

    task automatic model_reset();
        m_i = 0; m_yprev = 0; m_first = 1; m_hi = 0; m_lo = 0;
    endtask

    task automatic model_step(input longint pot, input longint rf, input longint kpv,
                              input longint kiv, input longint kdv,
                              output longint sal, output bit st);
        longint e, dy, pi, inew, p, d, u;
        bit ic;
        e  = rf - pot;
        dy = m_first ? 0 : pot - m_yprev;
        pi = (kiv * e) >>> FRAC;
        if ((m_hi && pi > 0) || (m_lo && pi < 0)) begin
            inew = m_i;
            ic   = 0;
        end else begin
            inew = clampw(m_i + pi);
            ic   = (inew != m_i + pi);
        end
        p   = (kpv * pot) >>> FRAC;
        d   = (kdv * dy) >>> FRAC;
        u   = inew - p - d;
        sal = clampw(u);
        st  = ic || (sal != u);
        m_hi = u > MAXV;
        m_lo = u < MINV;
        m_i = inew; m_yprev = pot; m_first = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, "_rst_salida"}, salida, 0);
        check({tag, "_rst_flags"}, {done, busy, sat}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one sample: drive, scramble inputs after acceptance, check timing
    task automatic do_sample(input int pot, input int rf, input int kpv, input int kiv,
                             input int kdv, input string tag);
        int lat, bcnt;
        @(negedge clk);
        Pot = W'(pot); Ref = W'(rf); kp = W'(kpv); ki = W'(kiv); kd = W'(kdv);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        Pot = W'($urandom); Ref = W'($urandom); kp = W'($urandom); ki = W'($urandom); kd = W'($urandom);
        lat = -1; bcnt = 0;
        for (int k = 0; k <= 20; k++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({tag, "_latency"}, lat, 6);
        check({tag, "_busy_cycles"}, bcnt, 5);
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, done, 0);
    endtask

    typedef struct {
        bit rs;
        int pot, rf, kpv, kiv, kdv;
        int sal;
        bit st;
    } vec_t;

    vec_t tbl[15];

    initial begin
        longint esal;
        bit     est;
        int     ndone;

        tbl[0]  = '{1, 100, 196, 256, 0, 0, -100, 0};
        tbl[1]  = '{1, 100, 196, 0, 128, 0, 48, 0};
        tbl[2]  = '{0, 100, 196, 0, 128, 0, 96, 0};
        tbl[3]  = '{0, 100, 196, 0, 128, 0, 144, 0};
        tbl[4]  = '{1, -4096, 4095, 0, 256, 0, 4095, 1};
        tbl[5]  = '{0, -4096, 4095, 0, 256, 0, 4095, 1};
        tbl[6]  = '{0, 100, 0, 0, 256, 0, 3995, 0};
        tbl[7]  = '{1, 50, 0, 0, 0, 256, 0, 0};
        tbl[8]  = '{0, 80, 0, 0, 0, 256, -30, 0};
        tbl[9]  = '{0, 80, 0, 0, 0, 256, 0, 0};
        tbl[10] = '{1, 3, 0, 128, 0, 0, -1, 0};
        tbl[11] = '{0, -3, 0, 128, 0, 0, 2, 0};
        tbl[12] = '{1, 2000, 2100, -512, 256, 0, 4095, 1};
        tbl[13] = '{0, 2000, 2100, -512, 256, 0, 4095, 1};
        tbl[14] = '{0, 2000, 1900, -512, 256, 0, 4000, 0};

        repeat (3) @(posedge clk);
        #1;
        check("por_salida", salida, 0);
        check("por_flags", {done, busy, sat}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            if (tbl[i].rs) do_reset(tag);
            do_sample(tbl[i].pot, tbl[i].rf, tbl[i].kpv, tbl[i].kiv, tbl[i].kdv, tag);
            check({tag, "_salida"}, salida, tbl[i].sal);
            check({tag, "_sat"}, sat, tbl[i].st);
        end

        // en re-pulsed during busy must be ignored
        do_reset("hs");
        @(negedge clk);
        Pot = W'(10); Ref = '0; kp = W'(256); ki = '0; kd = '0;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            en = (k == 2 || k == 4);
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        en = 1'b0;
        check("hs_done_count", ndone, 1);
        check("hs_salida", salida, -10);

        // reset in MUL_P aborts; next sample is a fresh first sample
        do_reset("rm");
        do_sample(100, 196, 0, 128, 256, "rm_pre");
        check("rm_pre_salida", salida, 48);
        @(negedge clk);
        Pot = W'(300); Ref = W'(196); kp = '0; ki = W'(128); kd = W'(256);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rm_busy_before", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rm_abort_salida", salida, 0);
        check("rm_abort_flags", {done, busy, sat}, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("rm_no_done", ndone, 0);
        do_sample(120, 196, 0, 128, 256, "rm_post");
        check("rm_post_salida", salida, 38);

        // randomized samples against the reference model
        do_reset("rnd");
        model_reset();
        for (int n = 0; n < 200; n++) begin
            int pv, rv, kpv, kiv, kdv;
            pv = int'($urandom_range(0, 8191)) - 4096;
            rv = int'($urandom_range(0, 8191)) - 4096;
            if ($urandom_range(0, 3) == 0) begin
                kpv = int'($urandom_range(0, 8191)) - 4096;
                kiv = int'($urandom_range(0, 8191)) - 4096;
                kdv = int'($urandom_range(0, 8191)) - 4096;
            end else begin
                kpv = int'($urandom_range(0, 1200)) - 600;
                kiv = int'($urandom_range(0, 1200)) - 600;
                kdv = int'($urandom_range(0, 1200)) - 600;
            end
            if ($urandom_range(0, 3) == 0) pv = (pv < 0) ? -4096 : 4095;
            do_sample(pv, rv, kpv, kiv, kdv, $sformatf("rnd%0d", n));
            model_step(pv, rv, kpv, kiv, kdv, esal, est);
            check($sformatf("rnd%0d_salida", n), salida, esal);
            check($sformatf("rnd%0d_sat", n), sat, est);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
